// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN (adds input parity_odd).
module uart_tx_serializer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tx_en,
    input  logic                 nstop,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [7:0]           data_in,
    input  logic                 data_valid,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic                 data_ready,
    output logic                 txd,
    output logic                 busy
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;
`endif

    localparam logic [DIV_WIDTH-1:0] BAUD_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q;
    logic                 txd_q;
    logic [DIV_WIDTH-1:0] baud_q;
    logic [2:0]           bit_q;
    logic [7:0]           data_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic                 nstop_q;
`ifdef UART_TX_PARITY_EN
    logic                 par_odd_q;
`endif

    logic       bit_end;
    logic [2:0] next_bit;
    logic       accept;

    // Handshake: a byte transfers on a rising edge where data_valid & data_ready;
    // data_ready is high only in Idle with tx_en set and reset low, and the byte,
    // divisor and stop-bit count are captured on that same edge.
    assign data_ready = (state_q == IDLE) & tx_en & ~reset;
    assign accept     = data_valid & data_ready;
    assign bit_end    = (baud_q == div_q);
    assign next_bit   = bit_q + 3'd1;
    assign txd        = txd_q;
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            txd_q     <= 1'b1;
            baud_q    <= '0;
            bit_q     <= 3'd0;
            data_q    <= 8'd0;
            div_q     <= '0;
            nstop_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_odd_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    txd_q  <= 1'b1;
                    baud_q <= '0;
                    bit_q  <= 3'd0;
                    if (accept) begin
                        data_q    <= data_in;
                        div_q     <= div;
                        nstop_q   <= nstop;
`ifdef UART_TX_PARITY_EN
                        par_odd_q <= parity_odd;
`endif
                        state_q   <= START;
                        txd_q     <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        state_q <= DATA;
                        txd_q   <= data_q[0];
                    end else begin
                        baud_q <= baud_q + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            bit_q <= 3'd0;
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            txd_q   <= (^data_q) ^ par_odd_q;
`else
                            state_q <= STOP1;
                            txd_q   <= 1'b1;
`endif
                        end else begin
                            bit_q <= next_bit;
                            txd_q <= data_q[next_bit];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        state_q <= STOP1;
                        txd_q   <= 1'b1;
                    end else begin
                        baud_q <= baud_q + BAUD_ONE;
                    end
                end
`endif
                STOP1: begin
                    txd_q <= 1'b1;
                    if (bit_end) begin
                        baud_q  <= '0;
                        state_q <= nstop_q ? STOP2 : IDLE;
                    end else begin
                        baud_q <= baud_q + BAUD_ONE;
                    end
                end
                STOP2: begin
                    txd_q <= 1'b1;
                    if (bit_end) begin
                        baud_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + BAUD_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    txd_q   <= 1'b1;
                    baud_q  <= '0;
                    bit_q   <= 3'd0;
                end
            endcase
        end
    end

endmodule
